// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flush, data-memory freeze with timeout pulse.
// Control outputs are combinational (0 latency); optional perf counters via `define HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int MEM_TIMEOUT       = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ifid_rs1,
   input  logic [4:0]  ifid_rs2,
   input  logic [4:0]  idex_rd,
   input  logic        idex_mem_read,
   input  logic        branch_taken,
   input  logic        mem_busy,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        pipe_freeze,
   output logic        mem_timeout,
   output logic [1:0]  state_o,
   output logic [31:0] stall_count,
   output logic [31:0] flush_count
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LD_STALL = 2'd1,
      MEM_WAIT = 2'd2
   } state_t;

   localparam logic [2:0] LD_INIT  = 3'(LOAD_STALL_CYCLES - 1);
   localparam logic [7:0] WAIT_MAX = 8'(MEM_TIMEOUT);

   state_t     state, state_nxt;
   logic [2:0] ld_cnt, ld_cnt_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       timeout_nxt;
   logic       load_use;
   logic       run_dec;
   logic       pc_w, ifid_w, flush, bubble, freeze;

   assign load_use = idex_mem_read && (idex_rd != 5'd0) &&
                     ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         ld_cnt      <= 3'd0;
         wait_cnt    <= 8'd0;
         mem_timeout <= 1'b0;
      end else begin
         state       <= state_nxt;
         ld_cnt      <= ld_cnt_nxt;
         wait_cnt    <= wait_cnt_nxt;
         mem_timeout <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      ld_cnt_nxt   = ld_cnt;
      wait_cnt_nxt = wait_cnt;
      timeout_nxt  = 1'b0;
      run_dec      = 1'b0;
      pc_w         = 1'b0;
      ifid_w       = 1'b0;
      flush        = 1'b0;
      bubble       = 1'b0;
      freeze       = 1'b0;

      case (state)
         RUN: run_dec = 1'b1;
         LD_STALL: begin
            // A freeze abandons the remaining bubbles; the hazard is re-detected afterwards.
            if (mem_busy) begin
               run_dec = 1'b1;
            end else begin
               bubble     = 1'b1;
               ld_cnt_nxt = ld_cnt - 3'd1;
               if (ld_cnt == 3'd1)
                  state_nxt = RUN;
            end
         end
         MEM_WAIT: begin
            if (mem_busy) begin
               freeze      = 1'b1;
               timeout_nxt = (wait_cnt == WAIT_MAX - 8'd1);
               if (wait_cnt != WAIT_MAX)
                  wait_cnt_nxt = wait_cnt + 8'd1;
            end else begin
               run_dec = 1'b1;
            end
         end
         default: run_dec = 1'b1;
      endcase

      if (run_dec) begin
         if (mem_busy) begin
            freeze       = 1'b1;
            state_nxt    = MEM_WAIT;
            wait_cnt_nxt = 8'd1;
         end else if (branch_taken) begin
            pc_w      = 1'b1;
            ifid_w    = 1'b1;
            flush     = 1'b1;
            bubble    = 1'b1;
            state_nxt = RUN;
         end else if (load_use) begin
            bubble = 1'b1;
            if (LOAD_STALL_CYCLES == 1) begin
               state_nxt = RUN;
            end else begin
               state_nxt  = LD_STALL;
               ld_cnt_nxt = LD_INIT;
            end
         end else begin
            pc_w      = 1'b1;
            ifid_w    = 1'b1;
            state_nxt = RUN;
         end
      end
   end

   assign pc_write    = pc_w   & ~rst;
   assign ifid_write  = ifid_w & ~rst;
   assign ifid_flush  = flush  & ~rst;
   assign idex_bubble = bubble & ~rst;
   assign pipe_freeze = freeze & ~rst;
   assign state_o     = state;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count <= 32'd0;
         flush_count <= 32'd0;
      end else begin
         if (!ifid_write)
            stall_count <= stall_count + 32'd1;
         if (ifid_flush)
            flush_count <= flush_count + 32'd1;
      end
   end
`else
   assign stall_count = 32'd0;
   assign flush_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench: two controllers (1 and 3 load bubbles, timeout 4) share one stimulus stream.
module tb_hazard_stall_ctrl;

   localparam logic [4:0] NORMAL = 5'b11000;  // {pc_write, ifid_write, flush, bubble, freeze}
   localparam logic [4:0] STALL  = 5'b00010;
   localparam logic [4:0] BRANCH = 5'b11110;
   localparam logic [4:0] FREEZE = 5'b00001;

   logic clk, rst;
   logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
   logic idex_mem_read, branch_taken, mem_busy;
   logic pc1, iw1, fl1, bb1, fz1, to1, pc3, iw3, fl3, bb3, fz3, to3;
   logic [1:0] s1, s3;
   logic [31:0] sc1, fc1, sc3, fc3;
   int checks, errors;

   wire [4:0] o1 = {pc1, iw1, fl1, bb1, fz1};
   wire [4:0] o3 = {pc3, iw3, fl3, bb3, fz3};

   hazard_stall_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(4)) dut1 (
      .clk(clk), .rst(rst), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
      .idex_mem_read(idex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_write(pc1), .ifid_write(iw1), .ifid_flush(fl1), .idex_bubble(bb1),
      .pipe_freeze(fz1), .mem_timeout(to1), .state_o(s1),
      .stall_count(sc1), .flush_count(fc1));

   hazard_stall_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(4)) dut3 (
      .clk(clk), .rst(rst), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
      .idex_mem_read(idex_mem_read), .branch_taken(branch_taken), .mem_busy(mem_busy),
      .pc_write(pc3), .ifid_write(iw3), .ifid_flush(fl3), .idex_bubble(bb3),
      .pipe_freeze(fz3), .mem_timeout(to3), .state_o(s3),
      .stall_count(sc3), .flush_count(fc3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic mr, input logic br, input logic mb);
      @(negedge clk);
      ifid_rs1 = r1; ifid_rs2 = r2; idex_rd = rd;
      idex_mem_read = mr; branch_taken = br; mem_busy = mb;
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (o1 !== 5'b0 || o3 !== 5'b0) begin errors++; $display("FAIL reset_outs got %b/%b exp 00000", o1, o3); end
      checks++; if (s1 !== 2'd0 || s3 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d/%0d exp 0", s1, s3); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      checks++; if (o1 !== 5'b0 || to1 !== 1'b0) begin errors++; $display("FAIL reset_freeze got %b to=%b exp 00000 0", o1, to1); end
      checks++; if (sc1 !== 32'd0 || fc1 !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0", sc1, fc1); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   task automatic test_normal;
      drive(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
      checks++; if (o1 !== NORMAL || o3 !== NORMAL) begin errors++; $display("FAIL normal got %b/%b exp %b", o1, o3, NORMAL); end
      drive(5'd3, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
      checks++; if (o1 !== NORMAL || s1 !== 2'd0) begin errors++; $display("FAIL normal_noload got %b s=%0d exp %b 0", o1, s1, NORMAL); end
   endtask

   task automatic test_load_use;
      drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
      checks++; if (o1 !== STALL || o3 !== STALL) begin errors++; $display("FAIL lu_first got %b/%b exp %b", o1, o3, STALL); end
      checks++; if (s3 !== 2'd0) begin errors++; $display("FAIL lu_state0 got %0d exp 0", s3); end
      // branch while dut3 is in LD_STALL: dut1 (back in RUN) flushes, dut3 ignores it
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (o1 !== BRANCH) begin errors++; $display("FAIL lu1_after got %b exp %b", o1, BRANCH); end
      checks++; if (o3 !== STALL || s3 !== 2'd1) begin errors++; $display("FAIL lu3_second got %b s=%0d exp %b 1", o3, s3, STALL); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (o3 !== STALL || s3 !== 2'd1) begin errors++; $display("FAIL lu3_third got %b s=%0d exp %b 1", o3, s3, STALL); end
      checks++; if (o1 !== NORMAL || s1 !== 2'd0) begin errors++; $display("FAIL lu1_normal got %b s=%0d exp %b 0", o1, s1, NORMAL); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (o3 !== NORMAL || s3 !== 2'd0) begin errors++; $display("FAIL lu3_done got %b s=%0d exp %b 0", o3, s3, NORMAL); end
   endtask

   task automatic test_branch;
      drive(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
      checks++; if (o1 !== BRANCH || o3 !== BRANCH) begin errors++; $display("FAIL br_lu got %b/%b exp %b", o1, o3, BRANCH); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (s1 !== 2'd0 || s3 !== 2'd0 || o3 !== NORMAL) begin errors++; $display("FAIL br_nostall got %0d/%0d %b exp 0/0 %b", s1, s3, o3, NORMAL); end
   endtask

   task automatic test_rd_zero;
      drive(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
      checks++; if (o1 !== NORMAL || o3 !== NORMAL) begin errors++; $display("FAIL rd0 got %b/%b exp %b", o1, o3, NORMAL); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (s3 !== 2'd0) begin errors++; $display("FAIL rd0_state got %0d exp 0", s3); end
   endtask

   task automatic test_mem_wait;
      for (int i = 0; i < 10; i++) begin
         drive(5'd0, 5'd0, 5'd0, 1'b0, (i == 5), 1'b1);
         checks++; if (o1 !== FREEZE || o3 !== FREEZE) begin errors++; $display("FAIL mw_freeze[%0d] got %b/%b exp %b", i, o1, o3, FREEZE); end
         checks++; if (s1 !== ((i == 0) ? 2'd0 : 2'd2)) begin errors++; $display("FAIL mw_state[%0d] got %0d exp %0d", i, s1, (i == 0) ? 0 : 2); end
         checks++; if (to1 !== (i == 4) || to3 !== (i == 4)) begin errors++; $display("FAIL mw_timeout[%0d] got %b/%b exp %b", i, to1, to3, (i == 4)); end
      end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (o1 !== NORMAL || s1 !== 2'd2 || to1 !== 1'b0) begin errors++; $display("FAIL mw_exit got %b s=%0d to=%b exp %b 2 0", o1, s1, to1, NORMAL); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (s1 !== 2'd0) begin errors++; $display("FAIL mw_run got %0d exp 0", s1); end
   endtask

   task automatic test_ld_stall_mem_busy;
      drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      checks++; if (o3 !== FREEZE || s3 !== 2'd1) begin errors++; $display("FAIL lsmb_freeze got %b s=%0d exp %b 1", o3, s3, FREEZE); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (o3 !== NORMAL || s3 !== 2'd2) begin errors++; $display("FAIL lsmb_exit got %b s=%0d exp %b 2", o3, s3, NORMAL); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (s3 !== 2'd0) begin errors++; $display("FAIL lsmb_run got %0d exp 0", s3); end
   endtask

   task automatic test_reset_mid;
      drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      checks++; if (s3 !== 2'd1) begin errors++; $display("FAIL rm_pre got %0d exp 1", s3); end
      #2 rst = 1'b1;
      #1;
      checks++; if (s3 !== 2'd0 || o3 !== 5'b0 || o1 !== 5'b0) begin errors++; $display("FAIL rm_async got s=%0d %b/%b exp 0 00000", s3, o3, o1); end
      checks++; if (sc3 !== 32'd0 || fc1 !== 32'd0) begin errors++; $display("FAIL rm_cnt got %0d/%0d exp 0", sc3, fc1); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_perf_counters;
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      drive(5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      checks++; if (o1 !== BRANCH || o3 !== STALL) begin errors++; $display("FAIL pc_br got %b/%b exp %b/%b", o1, o3, BRANCH, STALL); end
      drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
      checks++; if (sc1 !== 32'd1 || fc1 !== 32'd1) begin errors++; $display("FAIL perf1 got %0d/%0d exp 1/1", sc1, fc1); end
      checks++; if (sc3 !== 32'd2 || fc3 !== 32'd0) begin errors++; $display("FAIL perf3 got %0d/%0d exp 2/0", sc3, fc3); end
`else
      checks++; if (sc1 !== 32'd0 || fc1 !== 32'd0 || sc3 !== 32'd0 || fc3 !== 32'd0) begin errors++; $display("FAIL perf_off got %0d/%0d/%0d/%0d exp 0", sc1, fc1, sc3, fc3); end
`endif
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b1;
      ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0;
      idex_mem_read = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
      test_reset();
      test_normal();
      test_load_use();
      test_branch();
      test_rd_zero();
      test_mem_wait();
      test_ld_stall_mem_busy();
      test_reset_mid();
      test_perf_counters();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter LOAD_STALL_CYCLES, default 1, range 1..7, bubble cycles inserted per load-use hazard.
REQ-002 Parameter MEM_TIMEOUT, default 64, range 2..255, MEM_WAIT cycles before mem_timeout pulses.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ifid_rs1, ifid_rs2  input  5 each  source register fields of the instruction held in IF/ID.
REQ-006 idex_rd  input  5  destination register of the instruction held in ID/EX.
REQ-007 idex_mem_read  input  1  ID/EX instruction is a load.
REQ-008 branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-009 mem_busy  input  1  data memory not ready; the whole pipeline must freeze.
REQ-010 pc_write, ifid_write  output  1 each  PC and IF/ID register write enables.
REQ-011 ifid_flush  output  1  clear IF/ID to NOP (32'h0000_0013) on the next edge.
REQ-012 idex_bubble  output  1  load NOP control word into ID/EX on the next edge.
REQ-013 pipe_freeze  output  1  hold all pipeline registers, including ID/EX, EX/MEM and MEM/WB.
REQ-014 mem_timeout  output  1  registered one-cycle error pulse.
REQ-015 state_o  output  2  current state: RUN=0, LD_STALL=1, MEM_WAIT=2; value 3 is unused.
REQ-016 stall_count, flush_count  output  32 each  performance counters (see Configuration).

Function
REQ-017 load_use SHALL equal idex_mem_read && idex_rd!=0 && (idex_rd==ifid_rs1 || idex_rd==ifid_rs2).
REQ-018 Control outputs SHALL be combinational from the current state and inputs; state, counters and mem_timeout SHALL be registered.
REQ-019 Decision in RUN, priority mem_busy > branch_taken > load_use > normal:
 - mem_busy: pipe_freeze=1, pc_write=0, ifid_write=0, flush=0, bubble=0; next MEM_WAIT; wait_cnt<=1.
 - branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; next RUN.
 - load_use: pc_write=0, ifid_write=0, idex_bubble=1; next RUN if LOAD_STALL_CYCLES==1, else LD_STALL with ld_cnt<=LOAD_STALL_CYCLES-1.
 - normal: pc_write=1, ifid_write=1, all other outputs 0.
REQ-020 In LD_STALL, outputs SHALL be pc_write=0, ifid_write=0, idex_bubble=1; ld_cnt decrements each cycle; when ld_cnt==1, next state is RUN.
REQ-021 In LD_STALL, branch_taken SHALL be ignored, because EX holds a bubble.
REQ-022 mem_busy=1 in LD_STALL SHALL apply the RUN mem_busy row and abandon ld_cnt; load_use is re-evaluated on return, since IF/ID and ID/EX were frozen.
REQ-023 In MEM_WAIT with mem_busy=1: pipe_freeze=1, pc_write=0, ifid_write=0; wait_cnt increments, saturating at MEM_TIMEOUT.
REQ-024 In MEM_WAIT with mem_busy=0, the RUN decision (REQ-019 rows 2-4) SHALL apply in that same cycle, with the transitions of RUN.
REQ-025 mem_timeout SHALL pulse high for exactly one cycle, on the edge where wait_cnt reaches MEM_TIMEOUT while mem_busy=1; no further pulse until MEM_WAIT is re-entered.
REQ-026 ifid_flush and ifid_write=0 SHALL never be asserted together; pipe_freeze=1 SHALL force ifid_flush=0 and idex_bubble=0.

Reset
REQ-027 While rst=1, all control outputs SHALL be 0: pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze and mem_timeout.
REQ-028 On rst assertion, state=RUN, ld_cnt=0, wait_cnt=0 and both perf counters=0, immediately and regardless of clk, including mid-stall or mid-wait.
REQ-029 After rst deasserts, the first edge SHALL evaluate from RUN.

Configuration
REQ-030 With HAZARD_PERF_CNT_EN defined, stall_count SHALL increment on each cycle with ifid_write=0 and rst=0, and flush_count on each cycle with ifid_flush=1; both wrap modulo 2^32.
REQ-031 Without HAZARD_PERF_CNT_EN, stall_count and flush_count SHALL be constant 0, and no counter flops are inferred.

Verification
REQ-032 Load-use, LOAD_STALL_CYCLES=1: idex_mem_read=1, idex_rd=5, ifid_rs2=5 for one cycle -> ifid_write=0 and idex_bubble=1 for 1 cycle, then normal.
REQ-033 LOAD_STALL_CYCLES=3, same hazard -> ifid_write=0 for 3 consecutive cycles, with state_o sequence 0,1,1,0.
REQ-034 branch_taken=1 together with load_use=1 -> ifid_flush=1, idex_bubble=1, pc_write=1 in that cycle, and no stall.
REQ-035 mem_busy high for 10 cycles, MEM_TIMEOUT=4 -> pipe_freeze=1 for 10 cycles, mem_timeout is a single pulse 4 cycles after entry, then RUN.
REQ-036 rst pulsed during LD_STALL -> state_o=0 and all outputs 0 immediately; with the macro, stall_count=0.
REQ-037 idex_rd=0 with idex_mem_read=1 and ifid_rs1=0 -> no stall.
